// File: rtl/regression_accumulator_if.sv
// Loader-side and result-side signals of the regression accumulator.
// The master drives start/x/y, and the slave (the accumulator) drives the index and sums.
interface regression_accumulator_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [19:0]      x;
   logic [19:0]      y;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             done;
   logic [27:0]      sum_x;
   logic [27:0]      sum_y;
   logic [47:0]      sum_xx;
   logic [47:0]      sum_xy;
   logic [47:0]      sum_yy;

   modport master (
      output start, x, y,
      input  cnt, busy, done, sum_x, sum_y, sum_xx, sum_xy, sum_yy
   );

   modport slave (
      input  start, x, y,
      output cnt, busy, done, sum_x, sum_y, sum_xx, sum_xy, sum_yy
   );
endinterface

// File: rtl/regression_accumulator.sv
// Sample sequencer and two-stage sum-of-products accumulator for the linear-regression datapath.
// Define REG_SUM_YY_EN to add the y*y product and the sum_yy accumulator; otherwise sum_yy is 0.
module regression_accumulator #(
   parameter int N     = 150,
   parameter int CNT_W = 8
) (
   input logic                     clk,
   input logic                     rst,
   regression_accumulator_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             done;
   logic             start_ok;
   logic             s1_valid;
   logic [19:0]      x_q;
   logic [19:0]      y_q;
   logic [39:0]      xx_q;
   logic [39:0]      xy_q;
   logic [27:0]      sum_x;
   logic [27:0]      sum_y;
   logic [47:0]      sum_xx;
   logic [47:0]      sum_xy;

   assign start_ok = bus.start && (state == IDLE || state == DONE);

   // NOTE: stage-1 data has no reset; s1_valid alone decides whether it is ever consumed.
   always_ff @(posedge clk) begin
      if (state == RUN) begin
         x_q  <= bus.x;
         y_q  <= bus.y;
         xx_q <= 40'(bus.x) * 40'(bus.x);
         xy_q <= 40'(bus.x) * 40'(bus.y);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         s1_valid <= 1'b0;
         sum_x    <= '0;
         sum_y    <= '0;
         sum_xx   <= '0;
         sum_xy   <= '0;
      end else begin
         // NOTE: non-blocking only, so a later clear in this block overrides the accumulate above it.
         s1_valid <= (state == RUN);
         if (s1_valid) begin
            sum_x  <= sum_x + {8'd0, x_q};
            sum_y  <= sum_y + {8'd0, y_q};
            sum_xx <= sum_xx + {8'd0, xx_q};
            sum_xy <= sum_xy + {8'd0, xy_q};
         end
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  state  <= RUN;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  done   <= 1'b0;
                  sum_x  <= '0;
                  sum_y  <= '0;
                  sum_xx <= '0;
                  sum_xy <= '0;
               end
            end
            RUN: begin
               if (cnt == LAST_CNT) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               // The last sample lands in the accumulators on this same edge.
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef REG_SUM_YY_EN
   logic [39:0] yy_q;
   logic [47:0] sum_yy;

   always_ff @(posedge clk) begin
      if (state == RUN) yy_q <= 40'(bus.y) * 40'(bus.y);
   end

   always_ff @(posedge clk) begin
      if (!rst)          sum_yy <= '0;
      else if (start_ok) sum_yy <= '0;
      else if (s1_valid) sum_yy <= sum_yy + {8'd0, yy_q};
   end

   assign bus.sum_yy = sum_yy;
`else
   assign bus.sum_yy = '0;
`endif

   assign bus.cnt    = cnt;
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.sum_x  = sum_x;
   assign bus.sum_y  = sum_y;
   assign bus.sum_xx = sum_xx;
   assign bus.sum_xy = sum_xy;

endmodule

// File: tb/tb_regression_accumulator.sv
// Scoreboard bench for regression_accumulator: an N=150 instance and an N=1 instance,
// each fed by a behavioural loader and checked against sums computed from the sample tables.
module tb_regression_accumulator;
   localparam int N = 150;

   typedef struct {
      logic [27:0] sx;
      logic [27:0] sy;
      logic [47:0] sxx;
      logic [47:0] sxy;
      logic [47:0] syy;
      int          cyc;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   regression_accumulator_if #(.CNT_W(8)) bus ();
   regression_accumulator_if #(.CNT_W(1)) bus1 ();

   regression_accumulator #(.N(N), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   regression_accumulator #(.N(1), .CNT_W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Loaders: combinational lookup of the sample addressed by cnt.
   logic [19:0] x_mem [256];
   logic [19:0] y_mem [256];
   logic [19:0] x1, y1;
   assign bus.x  = x_mem[bus.cnt];
   assign bus.y  = y_mem[bus.cnt];
   assign bus1.x = x1;
   assign bus1.y = y1;

   res_t q0[$];
   res_t q1[$];
   res_t hold [2];
   logic done_prev [2] = '{1'b0, 1'b0};
   int   busy_cyc [2] = '{0, 0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic cmp_res(input string tag, input res_t o, input res_t e);
      check({tag, "_sum_x"},  64'(o.sx),  64'(e.sx));
      check({tag, "_sum_y"},  64'(o.sy),  64'(e.sy));
      check({tag, "_sum_xx"}, 64'(o.sxx), 64'(e.sxx));
      check({tag, "_sum_xy"}, 64'(o.sxy), 64'(e.sxy));
      check({tag, "_sum_yy"}, 64'(o.syy), 64'(e.syy));
   endtask

   // Reference: plain sums over the first n table entries.
   function automatic res_t model(input logic [19:0] xs [256], input logic [19:0] ys [256],
                                  input int n, input int c0);
      res_t e;
      longint unsigned ax = 0, ay = 0, axx = 0, axy = 0, ayy = 0;
      for (int i = 0; i < n; i++) begin
         longint unsigned xi = 64'(xs[i]);
         longint unsigned yi = 64'(ys[i]);
         ax  += xi;
         ay  += yi;
         axx += xi * xi;
         axy += xi * yi;
         ayy += yi * yi;
      end
      e.sx  = 28'(ax);
      e.sy  = 28'(ay);
      e.sxx = 48'(axx);
      e.sxy = 48'(axy);
`ifdef REG_SUM_YY_EN
      e.syy = 48'(ayy);
`else
      e.syy = 48'd0;
`endif
      e.cyc = c0 + n + 1;
      return e;
   endfunction

   task automatic mon(input int id, input logic done, input logic busy, input int cnt_v,
                      input res_t o, input int n);
      res_t e;
      bit   got = 1'b0;
      string tag = $sformatf("m%0d", id);
      if (busy === 1'b1) busy_cyc[id]++;
      if (done === 1'b1 && done_prev[id] == 1'b0) begin
         if (id == 0 && q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
         if (id == 1 && q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
         check({tag, "_done_expected"}, 64'(got), 64'd1);
         if (got) begin
            cmp_res(tag, o, e);
            check({tag, "_done_cycle"}, 64'(o.cyc), 64'(e.cyc));
            check({tag, "_busy_cycles"}, 64'(busy_cyc[id]), 64'(n + 1));
            check({tag, "_cnt_at_done"}, 64'(cnt_v), 64'd0);
            hold[id] = e;
         end
      end else if (done === 1'b1) begin
         cmp_res({tag, "_hold"}, o, hold[id]);
      end
      if (busy !== 1'b1) busy_cyc[id] = 0;
      done_prev[id] = (done === 1'b1);
   endtask

   always @(negedge clk) begin
      res_t o;
      o.sx = bus.sum_x; o.sy = bus.sum_y; o.sxx = bus.sum_xx;
      o.sxy = bus.sum_xy; o.syy = bus.sum_yy; o.cyc = cyc;
      mon(0, bus.done, bus.busy, int'(bus.cnt), o, N);
   end

   always @(negedge clk) begin
      res_t o;
      o.sx = bus1.sum_x; o.sy = bus1.sum_y; o.sxx = bus1.sum_xx;
      o.sxy = bus1.sum_xy; o.syy = bus1.sum_yy; o.cyc = cyc;
      mon(1, bus1.done, bus1.busy, int'(bus1.cnt), o, 1);
   end

   task automatic check_idle(input string tag);
      check({tag, "_cnt"},    64'(bus.cnt),    64'd0);
      check({tag, "_busy"},   64'(bus.busy),   64'd0);
      check({tag, "_done"},   64'(bus.done),   64'd0);
      check({tag, "_sum_x"},  64'(bus.sum_x),  64'd0);
      check({tag, "_sum_y"},  64'(bus.sum_y),  64'd0);
      check({tag, "_sum_xx"}, 64'(bus.sum_xx), 64'd0);
      check({tag, "_sum_xy"}, 64'(bus.sum_xy), 64'd0);
      check({tag, "_sum_yy"}, 64'(bus.sum_yy), 64'd0);
   endtask

   // One run of the N=150 instance; extra start pulses at loop offsets p1/p2 must be ignored.
   task automatic run_main(input int p1, input int p2);
      int c0;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      c0 = cyc;
      q0.push_back(model(x_mem, y_mem, N, c0));
      for (int i = 0; i < N + 20 && q0.size() != 0; i++) begin
         @(negedge clk);
         bus.start = (i == p1 || i == p2);
      end
      bus.start = 1'b0;
      check("main_done_timeout", 64'(q0.size()), 64'd0);
   endtask

   task automatic run_one(input logic [19:0] xv, input logic [19:0] yv);
      logic [19:0] tx [256];
      logic [19:0] ty [256];
      int c0;
      foreach (tx[i]) begin tx[i] = '0; ty[i] = '0; end
      tx[0] = xv; ty[0] = yv;
      x1 = xv; y1 = yv;
      @(negedge clk); bus1.start = 1'b1;
      @(negedge clk); bus1.start = 1'b0;
      c0 = cyc;
      q1.push_back(model(tx, ty, 1, c0));
      for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge clk);
      check("n1_done_timeout", 64'(q1.size()), 64'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         x_mem[i] = 20'($urandom);
         y_mem[i] = 20'($urandom);
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.start = 1'b0;
      bus1.start = 1'b0;
      x1 = '0; y1 = '0;
      for (int i = 0; i < 256; i++) begin x_mem[i] = '0; y_mem[i] = '0; end
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset_n1_busy", 64'(bus1.busy), 64'd0);
      check("reset_n1_done", 64'(bus1.done), 64'd0);
      rst = 1'b1;

      // Constant 1.0 / 2.0 samples.
      for (int i = 0; i < 256; i++) begin x_mem[i] = 20'h00400; y_mem[i] = 20'h00800; end
      run_main(-1, -1);

      // Full-scale samples: largest possible sums.
      for (int i = 0; i < 256; i++) begin x_mem[i] = 20'hFFFFF; y_mem[i] = 20'hFFFFF; end
      run_main(-1, -1);

      // Ramp on x, y zero; start pulses mid-run are ignored.
      for (int i = 0; i < 256; i++) begin x_mem[i] = 20'(i << 10); y_mem[i] = '0; end
      run_main(9, 79);

      // Random data, back-to-back restarts from DONE.
      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_main(-1, -1);
      end

      // Reset at cycle 50 of a run, with start asserted alongside it.
      fill_random();
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      check_idle("midrst");
      repeat (3) @(negedge clk);
      check("midrst_no_done", 64'(bus.done), 64'd0);
      fill_random();
      run_main(-1, -1);

      // Single-sample instance.
      run_one(20'h00C00, 20'h00400);
      run_one(20'($urandom), 20'($urandom));
      run_one(20'hFFFFF, 20'hFFFFF);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
